fire2_squeeze_ofm_writer: RTL and testbench

Consumer end of the fire2_squeeze output interface. It captures the DSP_NO parallel output-feature-map words on each `fire2_squeeze_sample` pulse and serializes them into the channel-major activation RAM one word per cycle. While it is busy it drives `ram_feedback` back to the layer. It also tracks pixel progress and flags layer completion and any sample it had to drop.

---
 rtl/fire2_squeeze_ofm_writer.sv | 120 ++++++++++++
 tb/tb_fire2_squeeze_ofm_writer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fire2_squeeze_ofm_writer.sv
// Captures one pixel's DSP_NO channel results per sample pulse and serializes
// them into the channel-major activation RAM, one word per cycle.
module fire2_squeeze_ofm_writer #(
  parameter int WIDTH     = 16,
  parameter int DSP_NO    = 16,
  parameter int WOUT      = 64,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fire2_squeeze_sample,
  input  logic [WIDTH-1:0]  ofm [0:DSP_NO-1],
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_wdata,
  output logic              ram_feedback,
  output logic              layer_done,
  output logic              overflow
);
  localparam int W2     = WOUT * WOUT;
  localparam int LOG_W2 = $clog2(W2);
  localparam bit POW2   = (W2 & (W2 - 1)) == 0;
  localparam int CH_W   = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
  localparam int PIX_W  = LOG_W2 + 1;
  localparam logic [CH_W-1:0]  CH_LAST = CH_W'(DSP_NO - 1);
  localparam logic [PIX_W-1:0] PIX_END = PIX_W'(W2);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t            state, state_n;
  logic [CH_W-1:0]   ch, ch_n;
  logic [PIX_W-1:0]  pix, pix_n;
  logic [WIDTH-1:0]  buf_q [0:DSP_NO-1];
  logic              load, emit;
  logic              we_n, fb_n, done_n, ovf_n;
  logic [ADDR_W-1:0] addr_n;
  logic [WIDTH-1:0]  wdata_n;
  logic [31:0]       ch_off;

  // ch tracks the channel currently on the RAM port; outputs for the next
  // cycle are computed here and registered below.
  always_comb begin
    state_n = state;
    ch_n    = ch;
    pix_n   = pix;
    load    = 1'b0;
    emit    = 1'b0;
    done_n  = layer_done;
    ovf_n   = overflow;
    case (state)
      IDLE: if (fire2_squeeze_sample) begin
        load    = 1'b1;
        emit    = 1'b1;
        ch_n    = '0;
        state_n = WRITE;
      end
      WRITE: if (ch == CH_LAST) begin
        pix_n = pix + 1'b1;
        ch_n  = '0;
        if (pix_n == PIX_END) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else if (fire2_squeeze_sample) begin
          load = 1'b1;
          emit = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end else begin
        ch_n = ch + 1'b1;
        emit = 1'b1;
        if (fire2_squeeze_sample) ovf_n = 1'b1;
      end
      DONE:    done_n = 1'b1;
      default: state_n = IDLE;
    endcase

    if (POW2) ch_off = 32'(ch_n) << LOG_W2;
    else      ch_off = 32'(ch_n) * 32'(W2);

    we_n    = emit;
    fb_n    = emit;
    addr_n  = ram_addr;
    wdata_n = ram_wdata;
    if (emit) begin
      addr_n  = ADDR_W'(32'(BASE_ADDR) + ch_off + 32'(pix_n));
      wdata_n = load ? ofm[0] : buf_q[ch_n];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ch           <= '0;
      pix          <= '0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      ram_feedback <= 1'b0;
      layer_done   <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_n;
      ch           <= ch_n;
      pix          <= pix_n;
      ram_we       <= we_n;
      ram_addr     <= addr_n;
      ram_wdata    <= wdata_n;
      ram_feedback <= fb_n;
      layer_done   <= done_n;
      overflow     <= ovf_n;
    end
  end

  // Buffer needs no reset: it is always reloaded before any word is read.
  always_ff @(posedge clk) begin
    if (!rst && load) buf_q <= ofm;
  end
endmodule

// File: tb/tb_fire2_squeeze_ofm_writer.sv
// Directed bench: a 16ch/64x64 instance for burst timing, overflow and reset,
// plus a 4ch/2x2 instance for full-layer completion.
module tb_fire2_squeeze_ofm_writer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // big instance: DSP_NO=16, WOUT=64, BASE_ADDR=0
  logic        rst_b, smp_b;
  logic [15:0] ofm_b [0:15];
  logic        we_b, fb_b, done_b, ovf_b;
  logic [15:0] addr_b, wd_b;

  fire2_squeeze_ofm_writer #(.WIDTH(16), .DSP_NO(16), .WOUT(64), .BASE_ADDR(0), .ADDR_W(16)) u_big (
    .clk(clk), .rst(rst_b), .fire2_squeeze_sample(smp_b), .ofm(ofm_b),
    .ram_we(we_b), .ram_addr(addr_b), .ram_wdata(wd_b),
    .ram_feedback(fb_b), .layer_done(done_b), .overflow(ovf_b));

  // small instance: DSP_NO=4, WOUT=2, BASE_ADDR=8
  logic        rst_s, smp_s;
  logic [15:0] ofm_s [0:3];
  logic        we_s, fb_s, done_s, ovf_s;
  logic [15:0] addr_s, wd_s;

  fire2_squeeze_ofm_writer #(.WIDTH(16), .DSP_NO(4), .WOUT(2), .BASE_ADDR(8), .ADDR_W(16)) u_small (
    .clk(clk), .rst(rst_s), .fire2_squeeze_sample(smp_s), .ofm(ofm_s),
    .ram_we(we_s), .ram_addr(addr_s), .ram_wdata(wd_s),
    .ram_feedback(fb_s), .layer_done(done_s), .overflow(ovf_s));

  int wcnt = 0;
  int oob  = 0;
  int hits [0:31];
  initial for (int i = 0; i < 32; i++) hits[i] = 0;

  always @(negedge clk) begin
    if (we_s === 1'b1) begin
      wcnt++;
      if (addr_s < 16'd32) hits[addr_s]++;
      else oob++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_b(input string tag);
    chk({tag, "_we"},   {31'd0, we_b},   32'd0);
    chk({tag, "_addr"}, {16'd0, addr_b}, 32'd0);
    chk({tag, "_wd"},   {16'd0, wd_b},   32'd0);
    chk({tag, "_fb"},   {31'd0, fb_b},   32'd0);
    chk({tag, "_done"}, {31'd0, done_b}, 32'd0);
    chk({tag, "_ovf"},  {31'd0, ovf_b},  32'd0);
  endtask

  initial begin
    int cnt1;
    rst_b = 1'b1; smp_b = 1'b0;
    rst_s = 1'b1; smp_s = 1'b0;
    for (int i = 0; i < 16; i++) ofm_b[i] = '0;
    for (int i = 0; i < 4; i++)  ofm_s[i] = '0;
    step(); step();
    chk_reset_b("reset");
    chk("reset_s_we", {31'd0, we_s}, 32'd0);
    rst_b = 1'b0; rst_s = 1'b0;
    step();

    // single pixel (pix 0)
    chk("single_pre_fb", {31'd0, fb_b}, 32'd0);
    for (int i = 0; i < 16; i++) ofm_b[i] = 16'h100 + 16'(i);
    smp_b = 1'b1; step(); smp_b = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("single_we",   {31'd0, we_b},   32'd1);
      chk("single_fb",   {31'd0, fb_b},   32'd1);
      chk("single_addr", {16'd0, addr_b}, 32'(i * 4096));
      chk("single_data", {16'd0, wd_b},   32'h100 + 32'(i));
      step();
    end
    chk("single_post_we",   {31'd0, we_b},   32'd0);
    chk("single_post_fb",   {31'd0, fb_b},   32'd0);
    chk("single_post_done", {31'd0, done_b}, 32'd0);
    chk("single_post_ovf",  {31'd0, ovf_b},  32'd0);

    // back-to-back: pix 1 then pix 2 with no gap
    for (int i = 0; i < 16; i++) ofm_b[i] = 16'h200 + 16'(i);
    smp_b = 1'b1; step(); smp_b = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("b2b_we",   {31'd0, we_b},   32'd1);
      chk("b2b_fb",   {31'd0, fb_b},   32'd1);
      chk("b2b_addr", {16'd0, addr_b}, 32'((i % 16) * 4096 + (i < 16 ? 1 : 2)));
      chk("b2b_data", {16'd0, wd_b},   32'((i < 16 ? 16'h200 : 16'h300) + (i % 16)));
      if (i == 15) begin
        for (int j = 0; j < 16; j++) ofm_b[j] = 16'h300 + 16'(j);
        smp_b = 1'b1;
      end
      step();
      smp_b = 1'b0;
    end
    chk("b2b_post_we",  {31'd0, we_b},  32'd0);
    chk("b2b_post_fb",  {31'd0, fb_b},  32'd0);
    chk("b2b_post_ovf", {31'd0, ovf_b}, 32'd0);

    // overflow: pix 3, second sample at cycle 5 is dropped
    for (int i = 0; i < 16; i++) ofm_b[i] = 16'h400 + 16'(i);
    smp_b = 1'b1; step(); smp_b = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("ovf_we",   {31'd0, we_b},   32'd1);
      chk("ovf_addr", {16'd0, addr_b}, 32'(i * 4096 + 3));
      chk("ovf_data", {16'd0, wd_b},   32'h400 + 32'(i));
      if (i < 5) chk("ovf_flag_low", {31'd0, ovf_b}, 32'd0);
      else       chk("ovf_flag_high", {31'd0, ovf_b}, 32'd1);
      if (i == 4) begin
        for (int j = 0; j < 16; j++) ofm_b[j] = 16'hBAD0 + 16'(j);
        smp_b = 1'b1;
      end
      step();
      smp_b = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      chk("ovf_post_we",  {31'd0, we_b},  32'd0);
      chk("ovf_post_ovf", {31'd0, ovf_b}, 32'd1);
      step();
    end

    // next burst must use pix 4 (dropped sample did not advance pix)
    for (int i = 0; i < 16; i++) ofm_b[i] = 16'h600 + 16'(i);
    smp_b = 1'b1; step(); smp_b = 1'b0;
    chk("pix4_addr", {16'd0, addr_b}, 32'd4);
    chk("pix4_data", {16'd0, wd_b},   32'h600);
    for (int i = 0; i < 18; i++) step();

    // reset mid-burst at cycle 7
    for (int i = 0; i < 16; i++) ofm_b[i] = 16'h500 + 16'(i);
    smp_b = 1'b1; step(); smp_b = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("rstmid_we_c7", {31'd0, we_b}, 32'd1);
    rst_b = 1'b1; step(); rst_b = 1'b0;
    chk_reset_b("rstmid");
    step(); step();
    chk("rstmid_idle_we", {31'd0, we_b}, 32'd0);
    smp_b = 1'b1; step(); smp_b = 1'b0;
    chk("rstmid_addr0", {16'd0, addr_b}, 32'd0);
    chk("rstmid_data0", {16'd0, wd_b},   32'h500);
    step();
    chk("rstmid_addr1", {16'd0, addr_b}, 32'd4096);
    chk("rstmid_data1", {16'd0, wd_b},   32'h501);
    for (int i = 0; i < 16; i++) step();

    // full layer on the small instance
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 4; c++) ofm_s[c] = 16'h00A0 + 16'(4 * p + c);
      smp_s = 1'b1; step(); smp_s = 1'b0;
      for (int t = 1; t < 20; t++) begin
        if (t <= 4) begin
          chk("layer_we",   {31'd0, we_s},   32'd1);
          chk("layer_addr", {16'd0, addr_s}, 32'(8 + 4 * (t - 1) + p));
          chk("layer_data", {16'd0, wd_s},   32'(16'h00A0 + 4 * p + (t - 1)));
        end
        if (p == 3 && t == 4) chk("layer_done_early", {31'd0, done_s}, 32'd0);
        if (p == 3 && t == 5) chk("layer_done_rise",  {31'd0, done_s}, 32'd1);
        step();
      end
    end
    chk("layer_wcnt", 32'(wcnt), 32'd16);
    cnt1 = 0;
    for (int a = 8; a < 24; a++) if (hits[a] == 1) cnt1++;
    chk("layer_cover", 32'(cnt1), 32'd16);
    chk("layer_oob",   32'(oob),  32'd0);

    smp_s = 1'b1; step(); smp_s = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("done_ignore_wcnt", 32'(wcnt),        32'd16);
    chk("done_ignore_ovf",  {31'd0, ovf_s},   32'd0);
    chk("done_sticky",      {31'd0, done_s},  32'd1);
    chk("done_fb",          {31'd0, fb_s},    32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
